// File: rtl/npu_act_mem_arbiter_pkg.sv
// npu_act_mem_arbiter_pkg: grant encoding and activation-memory geometry defaults
`ifndef LOG2_ACT_ADDR_WIDTH
`define LOG2_ACT_ADDR_WIDTH 12
`endif
`ifndef ACT_MEM_DEPTH
`define ACT_MEM_DEPTH 3968
`endif
package npu_act_mem_arbiter_pkg;
    typedef logic [2:0] gnt_t;
    localparam gnt_t GNT_NONE = 3'b000;
    localparam gnt_t GNT_H    = 3'b001;
    localparam gnt_t GNT_R    = 3'b010;
    localparam gnt_t GNT_S    = 3'b100;
endpackage

// File: rtl/npu_arb_prio3.sv
// npu_arb_prio3: H > R > S one-hot picker; promote_s lifts S above R but never above H
module npu_arb_prio3
    import npu_act_mem_arbiter_pkg::*;
(
    input  logic h,
    input  logic r,
    input  logic s,
    input  logic promote_s,
    output gnt_t gnt
);
    always_comb gnt = h ? GNT_H : (s && promote_s) ? GNT_S : r ? GNT_R : s ? GNT_S : GNT_NONE;
endmodule

// File: rtl/npu_act_mem_arbiter.sv
// npu_act_mem_arbiter: shares the single-port activation BRAM between post-proc writes,
// MAC operand reads and the host port, with a starvation guard for the host.
module npu_act_mem_arbiter
    import npu_act_mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = `LOG2_ACT_ADDR_WIDTH,
    parameter int MEM_DEPTH    = `ACT_MEM_DEPTH,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hw_mem_wr,
    input  logic [ADDR_WIDTH-1:0] hw_mem_wr_addr,
    input  logic [DATA_WIDTH-1:0] hw_mem_wr_data,
    output logic                  hw_mem_wr_ack_p,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ack_p,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid_p,
    input  logic                  sw_req,
    input  logic                  sw_we,
    input  logic [ADDR_WIDTH-1:0] sw_addr,
    input  logic [DATA_WIDTH-1:0] sw_wdata,
    output logic                  sw_ack_p,
    output logic [DATA_WIDTH-1:0] sw_rdata,
    output logic                  sw_rdata_valid_p,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  addr_err,
    input  logic                  err_clr
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = STARVE_LIMIT[CW-1:0];
    localparam logic [ADDR_WIDTH:0] DEPTH = MEM_DEPTH[ADDR_WIDTH:0];

    gnt_t                  gnt;
    logic                  h_ok, r_ok, s_ok, promote, any, g_we, g_oor, issue;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic [CW-1:0]         starve_cnt;
    logic                  sw_rd_pend, pend_oor, vld_oor;

    // a port acked this cycle still shows its old request, so it sits out one round
    assign h_ok    = hw_mem_wr && !hw_mem_wr_ack_p;
    assign r_ok    = rd_req && !rd_ack_p;
    assign s_ok    = sw_req && !sw_ack_p;
    assign promote = starve_cnt == LIMIT;

    npu_arb_prio3 u_prio (
        .h         (h_ok),
        .r         (r_ok),
        .s         (s_ok),
        .promote_s (promote),
        .gnt       (gnt)
    );

    always_comb begin
        any     = |gnt;
        g_addr  = gnt[0] ? hw_mem_wr_addr : gnt[1] ? rd_addr : sw_addr;
        g_wdata = gnt[0] ? hw_mem_wr_data : sw_wdata;
        g_we    = gnt[0] || (gnt[2] && sw_we);
        g_oor   = {1'b0, g_addr} >= DEPTH;
        issue   = any && !g_oor;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hw_mem_wr_ack_p  <= 1'b0;
            rd_ack_p         <= 1'b0;
            sw_ack_p         <= 1'b0;
            mem_en           <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            sw_rd_pend       <= 1'b0;
            pend_oor         <= 1'b0;
            rd_data_valid_p  <= 1'b0;
            sw_rdata_valid_p <= 1'b0;
            vld_oor          <= 1'b0;
            addr_err         <= 1'b0;
            starve_cnt       <= '0;
        end else begin
            hw_mem_wr_ack_p  <= gnt[0];
            rd_ack_p         <= gnt[1];
            sw_ack_p         <= gnt[2];
            mem_en           <= issue;
            mem_we           <= issue && g_we;
            if (issue) mem_addr <= g_addr;
            if (issue && g_we) mem_wdata <= g_wdata;
            sw_rd_pend       <= gnt[2] && !sw_we;
            pend_oor         <= any && g_oor;
            rd_data_valid_p  <= rd_ack_p;
            sw_rdata_valid_p <= sw_rd_pend;
            vld_oor          <= pend_oor;
            addr_err         <= (any && g_oor) || (addr_err && !err_clr);
            starve_cnt       <= (!sw_req || gnt[2]) ? '0 : (s_ok && !promote) ? starve_cnt + 1'b1 : starve_cnt;
        end
    end

    // out-of-range reads never touched the BRAM, so their data is forced to zero
    assign rd_data  = (rd_data_valid_p && !vld_oor) ? mem_rdata : '0;
    assign sw_rdata = (sw_rdata_valid_p && !vld_oor) ? mem_rdata : '0;
endmodule

// File: tb/tb_npu_act_mem_arbiter.sv
// tb_npu_act_mem_arbiter: directed checks of grant timing, priority, starvation and range errors
module tb_npu_act_mem_arbiter;
    logic        clk, rst;
    logic        hw_mem_wr, hw_mem_wr_ack_p;
    logic [11:0] hw_mem_wr_addr;
    logic [7:0]  hw_mem_wr_data;
    logic        rd_req, rd_ack_p, rd_data_valid_p;
    logic [11:0] rd_addr;
    logic [7:0]  rd_data;
    logic        sw_req, sw_we, sw_ack_p, sw_rdata_valid_p;
    logic [11:0] sw_addr;
    logic [7:0]  sw_wdata, sw_rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        addr_err, err_clr;
    logic [7:0]  mem [4096];
    int          n_pass, n_total, n_fail;
    int          hn, rn;
    logic        hadv, radv;

    npu_act_mem_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .hw_mem_wr        (hw_mem_wr),
        .hw_mem_wr_addr   (hw_mem_wr_addr),
        .hw_mem_wr_data   (hw_mem_wr_data),
        .hw_mem_wr_ack_p  (hw_mem_wr_ack_p),
        .rd_req           (rd_req),
        .rd_addr          (rd_addr),
        .rd_ack_p         (rd_ack_p),
        .rd_data          (rd_data),
        .rd_data_valid_p  (rd_data_valid_p),
        .sw_req           (sw_req),
        .sw_we            (sw_we),
        .sw_addr          (sw_addr),
        .sw_wdata         (sw_wdata),
        .sw_ack_p         (sw_ack_p),
        .sw_rdata         (sw_rdata),
        .sw_rdata_valid_p (sw_rdata_valid_p),
        .mem_en           (mem_en),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .addr_err         (addr_err),
        .err_clr          (err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // BRAM model: word i powers up as i ^ 0x13, one-cycle read latency
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'(i) ^ 8'h13;
            mem_rdata <= 8'h00;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= mem[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hack"}, 32'(hw_mem_wr_ack_p), 0);
        chk({tag, "_rack"}, 32'(rd_ack_p), 0);
        chk({tag, "_sack"}, 32'(sw_ack_p), 0);
        chk({tag, "_rvld"}, 32'(rd_data_valid_p), 0);
        chk({tag, "_svld"}, 32'(sw_rdata_valid_p), 0);
        chk({tag, "_en"}, 32'(mem_en), 0);
        chk({tag, "_we"}, 32'(mem_we), 0);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_err"}, 32'(addr_err), 0);
        chk({tag, "_rdata"}, 32'(rd_data), 0);
        chk({tag, "_srdata"}, 32'(sw_rdata), 0);
    endtask

    // H and R request every cycle; S read starts at s_start and should be acked at ack_win
    task automatic run_starve(input int s_start, input int ack_win);
        hw_mem_wr = 1'b1; hw_mem_wr_addr = 12'h400; hw_mem_wr_data = 8'h11;
        rd_req = 1'b1; rd_addr = 12'h050;
        sw_we = 1'b0; sw_addr = 12'h060;
        for (int k = 0; k <= ack_win + 1; k++) begin
            if (k >= 1 && k <= ack_win) chk("starve_sack", 32'(sw_ack_p), 32'(k == ack_win));
            if (k == ack_win - 1 || k == ack_win) chk("starve_h_first", 32'(hw_mem_wr_ack_p), 32'(k == ack_win - 1));
            if (k == ack_win + 1) begin
                chk("starve_svld", 32'(sw_rdata_valid_p), 1);
                chk("starve_sdata", 32'(sw_rdata), 32'h73);
                sw_req = 1'b0;
            end
            if (k == s_start) sw_req = 1'b1;
            tick();
        end
        hw_mem_wr = 1'b0; rd_req = 1'b0;
        tick(); tick(); tick();
    endtask

    initial begin
        n_pass = 0; n_total = 0; n_fail = 0;
        rst = 1'b1; err_clr = 1'b0;
        hw_mem_wr = 1'b0; hw_mem_wr_addr = '0; hw_mem_wr_data = '0;
        rd_req = 1'b0; rd_addr = '0;
        sw_req = 1'b0; sw_we = 1'b0; sw_addr = '0; sw_wdata = '0;
        tick(); tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // sole H write
        hw_mem_wr = 1'b1; hw_mem_wr_addr = 12'h010; hw_mem_wr_data = 8'h5A;
        tick();
        chk("h_ack", 32'(hw_mem_wr_ack_p), 1);
        chk("h_en", 32'(mem_en), 1);
        chk("h_we", 32'(mem_we), 1);
        chk("h_addr", 32'(mem_addr), 32'h010);
        chk("h_wdata", 32'(mem_wdata), 32'h5A);
        tick();
        chk("h_no_regrant", 32'(hw_mem_wr_ack_p), 0);
        chk("idle_en", 32'(mem_en), 0);
        chk("idle_hold_addr", 32'(mem_addr), 32'h010);
        chk("idle_hold_wdata", 32'(mem_wdata), 32'h5A);
        hw_mem_wr = 1'b0;
        tick();

        // sole R read
        rd_req = 1'b1; rd_addr = 12'h020;
        tick();
        chk("r_ack", 32'(rd_ack_p), 1);
        chk("r_en", 32'(mem_en), 1);
        chk("r_we", 32'(mem_we), 0);
        chk("r_addr", 32'(mem_addr), 32'h020);
        chk("r_vld_early", 32'(rd_data_valid_p), 0);
        tick();
        chk("r_ack_once", 32'(rd_ack_p), 0);
        chk("r_vld", 32'(rd_data_valid_p), 1);
        chk("r_data", 32'(rd_data), 32'h33);
        rd_req = 1'b0;
        tick();

        // S read back of the H write
        sw_req = 1'b1; sw_we = 1'b0; sw_addr = 12'h010;
        tick();
        chk("s_ack", 32'(sw_ack_p), 1);
        tick();
        chk("s_vld", 32'(sw_rdata_valid_p), 1);
        chk("s_data", 32'(sw_rdata), 32'h5A);
        sw_req = 1'b0;
        tick();

        // H and R continuous, 10 accesses each, alternating
        hw_mem_wr = 1'b1; hw_mem_wr_addr = 12'h300; hw_mem_wr_data = 8'hA0;
        rd_req = 1'b1; rd_addr = 12'h040;
        hn = 0; rn = 0; hadv = 1'b0; radv = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            tick();
            if (k <= 20) chk("hr_alt", 32'({hw_mem_wr_ack_p, rd_ack_p}), (k % 2 == 1) ? 2 : 1);
            chk("hr_rvld", 32'(rd_data_valid_p), 32'(k >= 3 && k % 2 == 1));
            if (k >= 3 && k % 2 == 1) chk("hr_rdata", 32'(rd_data), 32'((8'h40 + 8'((k - 3) / 2)) ^ 8'h13));
            if (k <= 19 && k % 2 == 1) begin
                chk("hr_waddr", 32'(mem_addr), 32'h300 + 32'((k - 1) / 2));
                chk("hr_wdata", 32'(mem_wdata), 32'hA0 + 32'((k - 1) / 2));
            end
            if (hadv) begin
                hadv = 1'b0; hn++;
                if (hn == 10) hw_mem_wr = 1'b0;
                else begin
                    hw_mem_wr_addr = 12'h300 + 12'(hn);
                    hw_mem_wr_data = 8'hA0 + 8'(hn);
                end
            end
            if (hw_mem_wr_ack_p) hadv = 1'b1;
            if (radv) begin
                radv = 1'b0; rn++;
                if (rn == 10) rd_req = 1'b0;
                else rd_addr = 12'h040 + 12'(rn);
            end
            if (rd_ack_p) radv = 1'b1;
        end
        tick(); tick();

        // starvation guard: S promoted when H is masked, and waits for H otherwise
        run_starve(1, 18);
        run_starve(2, 20);

        // out-of-range S write, then clear
        sw_req = 1'b1; sw_we = 1'b1; sw_addr = 12'hF80; sw_wdata = 8'h77;
        tick();
        chk("oor_sack", 32'(sw_ack_p), 1);
        chk("oor_en", 32'(mem_en), 0);
        chk("oor_err", 32'(addr_err), 1);
        sw_req = 1'b0; sw_we = 1'b0;
        tick();
        chk("err_sticky", 32'(addr_err), 1);
        err_clr = 1'b1;
        tick();
        chk("err_clr", 32'(addr_err), 0);

        // out-of-range R read together with err_clr: set wins, data forced to 0
        rd_req = 1'b1; rd_addr = 12'hFFF;
        tick();
        err_clr = 1'b0;
        chk("oor_rack", 32'(rd_ack_p), 1);
        chk("oor_ren", 32'(mem_en), 0);
        chk("err_set_wins", 32'(addr_err), 1);
        tick();
        chk("oor_rvld", 32'(rd_data_valid_p), 1);
        chk("oor_rdata", 32'(rd_data), 0);
        rd_req = 1'b0;
        tick();

        // reset right after a read issue drops its valid pulse
        rd_req = 1'b1; rd_addr = 12'h020;
        tick();
        chk("pre_rst_rack", 32'(rd_ack_p), 1);
        rst = 1'b1; rd_req = 1'b0;
        tick();
        chk_all_zero("mid_reset");
        rst = 1'b0;
        tick();
        chk("post_rst_rvld", 32'(rd_data_valid_p), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/npu_act_mem_arbiter.md
Name: npu_act_mem_arbiter

Overview:
Arbitrates the single-port activation memory (1-cycle read latency) between three requesters:
- H: the NPU post-processing write port (maxpool/ReLU output; level request held until ack pulse).
- R: the MAC operand-fetch read port.
- S: the host/loader port (image load, result readback).

Fixed priority H > R > S, with a starvation guard for S. The block sits between the NPU datapath and the activation BRAM.

Parameters:
- DATA_WIDTH, 8, activation word width.
- ADDR_WIDTH, `LOG2_ACT_ADDR_WIDTH, activation address width.
- MEM_DEPTH, 3968, valid words; addresses >= MEM_DEPTH are out of range.
- STARVE_LIMIT, 16, cycles S may wait while R wins before S is promoted above R.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- hw_mem_wr  in  1  H write request (level, held until ack)
- hw_mem_wr_addr  in  ADDR_WIDTH  H address
- hw_mem_wr_data  in  DATA_WIDTH  H data
- hw_mem_wr_ack_p  out  1  H ack, one-cycle pulse
- rd_req  in  1  R read request (level)
- rd_addr  in  ADDR_WIDTH  R address
- rd_ack_p  out  1  R ack pulse
- rd_data  out  DATA_WIDTH  R read data (= mem_rdata)
- rd_data_valid_p  out  1  rd_data valid pulse
- sw_req  in  1  S request (level)
- sw_we  in  1  S 1=write, 0=read
- sw_addr  in  ADDR_WIDTH  S address
- sw_wdata  in  DATA_WIDTH  S write data
- sw_ack_p  out  1  S ack pulse
- sw_rdata  out  DATA_WIDTH  S read data (= mem_rdata)
- sw_rdata_valid_p  out  1  sw_rdata valid pulse
- mem_en  out  1  BRAM enable
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_WIDTH  BRAM address
- mem_wdata  out  DATA_WIDTH  BRAM write data
- mem_rdata  in  DATA_WIDTH  BRAM read data (valid the cycle after mem_en & ~mem_we)
- addr_err  out  1  sticky out-of-range flag
- err_clr  in  1  clears addr_err

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs 0; starvation counter 0; pending read-valid pipeline flushed.
  - A read issued the cycle before reset produces no valid pulse.
- Grant timing:
  - Grant is decided combinationally in cycle N from the requests; mem_* and the *_ack_p outputs are registered and visible in N+1.
  - At most one grant per cycle.
- Ack masking: a requester whose ack_p is high in cycle N+1 is excluded from arbitration in N+1, because its request is still visible until N+2. Each port therefore sustains one access per 2 cycles; back-to-back grants to different ports are allowed.
- Priority:
  - H over everything.
  - Then R over S, unless starve_cnt == STARVE_LIMIT, in which case S beats R (but never H).
- Starvation counter (saturating, width clog2(STARVE_LIMIT+1)):
  - Increments each cycle S is requesting, unmasked, and not granted.
  - Clears on an S grant or when sw_req=0.
- Write grant: mem_en=1, mem_we=1, mem_addr/mem_wdata from the granted port; ack pulses in the same cycle.
- Read grant: mem_en=1, mem_we=0; ack pulses in N+1. The matching *_valid_p pulses in N+2, aligned with mem_rdata; rd_data/sw_rdata are direct mem_rdata passthroughs.
- Out-of-range address (addr >= MEM_DEPTH):
  - Ack still pulses; mem_en stays 0; addr_err set.
  - For reads, the valid pulse still occurs with data forced to 0.
- addr_err: sticky; err_clr clears it. If err_clr and a new error occur in the same cycle, set wins.
- Idle: mem_en=0; mem_addr and mem_wdata hold their previous values.
- Simultaneous H and R every cycle: H is served on alternate cycles (while it is masked), and R fills the gaps.
- Protocol: requesters must hold address and data stable from request until ack. The block does not re-sample them after grant.

Decomposition:
- npu_defines.vh supplies LOG2_ACT_ADDR_WIDTH and a new ACT_MEM_DEPTH define (default for MEM_DEPTH).
- Local grant one-hot encoding: GNT_NONE / GNT_H / GNT_R / GNT_S as localparams.
- One natural sub-module: npu_arb_prio3, a combinational priority picker with a promote-S input. The registered outputs, masking, counter and read pipeline stay in the top module.

Test Plan:
- Sole H write, addr 0x010, data 0x5A: mem_we=1, mem_addr=0x010, mem_wdata=0x5A and hw_mem_wr_ack_p all in the cycle after the request; H is not re-granted the following cycle.
- Sole R read of 0x020 (BRAM holds 0x33): rd_ack_p at N+1; rd_data_valid_p at N+2 with rd_data=0x33.
- H and R requesting continuously, 10 accesses each: grants alternate H,R,H,R…; no duplicate acks; every R read returns the correct data.
- R requesting continuously, S read pending: S granted after exactly 16 cycles of waiting (STARVE_LIMIT=16), not before, and never ahead of a concurrent H.
- S write to 0xF80 (= MEM_DEPTH): sw_ack_p pulses, mem_en stays 0, addr_err=1; err_clr pulse → addr_err=0.
- rst asserted the cycle after an R read issue: no rd_data_valid_p; all outputs 0 the cycle after reset.
